// File: rtl/imem_loader_pkg.sv
// ------------------------------------------------------------------------
// imem_loader_pkg : loader state encoding and instruction-memory geometry
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package imem_loader_pkg;

  localparam int IMEM_DEPTH   = 2048;
  localparam int IMEM_BYTE_AW = 13;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ------------------------------------------------------------------------
// byte_packer : lane counter and little-endian 32-bit word assembler
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane;
  logic [23:0] partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane    <= 2'd0;
      partial <= 24'd0;
    end else if (clear) begin
      lane    <= 2'd0;
      partial <= 24'd0;
    end else if (byte_valid) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    partial[7:0]   <= byte_in;
        2'd1:    partial[15:8]  <= byte_in;
        2'd2:    partial[23:16] <= byte_in;
        default: partial        <= 24'd0;
      endcase
    end
  end

  // Completed word is presented in the same cycle as its lane-3 byte.
  assign word       = {byte_in, partial};
  assign word_valid = byte_valid && (lane == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ------------------------------------------------------------------------
// imem_loader : framed byte-stream loader driving the instruction memory
// Optional IMEM_LOADER_CHECKSUM_EN adds a summed trailer check. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int CNT_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_words
);

  state_t           state, state_nxt;
  logic             accept, start_ok, word_valid;
  logic [31:0]      word;
  logic [CNT_W-1:0] n_words, words_inc;

  assign accept    = i_rx_valid && o_rx_ready;
  assign start_ok  = i_start && (state inside {IDLE, DONE, ERR});
  assign words_inc = o_words + {{(CNT_W-1){1'b0}}, 1'b1};

  byte_packer u_packer (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .clear      (start_ok),
    .byte_valid (accept),
    .byte_in    (i_rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t LAST_ST = CHK;
  logic [31:0] sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum <= 32'd0;
    end else if (start_ok) begin
      sum <= 32'd0;
    end else if (word_valid && state == DATA) begin
      sum <= sum + word;
    end
  end
`else
  localparam state_t LAST_ST = DONE;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    o_rx_ready = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_err      = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = HDR;
      end
      HDR: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
        if (word_valid) begin
          if (word > 32'(DEPTH))  state_nxt = ERR;
          else if (word == 32'd0) state_nxt = LAST_ST;
          else                    state_nxt = DATA;
        end
      end
      DATA: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
        if (word_valid && words_inc == n_words) state_nxt = LAST_ST;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
        if (word_valid) state_nxt = (word == sum) ? DONE : ERR;
      end
`endif
      DONE: begin
        o_done = 1'b1;
        if (i_start) state_nxt = HDR;
      end
      ERR: begin
        o_err = 1'b1;
        if (i_start) state_nxt = HDR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Header fits CNT_W once it has passed the DEPTH check, so only low bits are kept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n_words    <= '0;
      o_words    <= '0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= 32'd0;
      o_mem_data <= 32'd0;
    end else begin
      o_mem_we <= 1'b0;
      if (start_ok) begin
        n_words <= '0;
        o_words <= '0;
      end else if (word_valid && state == HDR) begin
        n_words <= word[CNT_W-1:0];
      end else if (word_valid && state == DATA) begin
        o_mem_we   <= 1'b1;
        o_mem_data <= word;
        o_mem_addr <= {{(30-CNT_W){1'b0}}, o_words, 2'b00};
        o_words    <= words_inc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ------------------------------------------------------------------------
// tb_imem_loader : directed frames checked against a queue-based write model
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [7:0]       i_rx_data = 8'd0;
  logic             i_rx_valid = 1'b0;
  logic             o_rx_ready, o_mem_we, o_busy, o_done, o_err;
  logic [31:0]      o_mem_addr, o_mem_data;
  logic [CNT_W-1:0] o_words;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         cur;
  int          model_words = 0;
  int          nvec = 0;
  int          nfail = 0;
  logic [31:0] wbuf [32];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(2048), .CNT_W(CNT_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_rx_ready (o_rx_ready),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_words    (o_words)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [31:0] data);
    wr_t e;
    e.addr = 32'(4 * idx);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (!o_rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_rx_ready) begin
      nvec++;
      nfail++;
      $display("FAIL byte_timeout: ready stayed 0, expected 1 within 200 cycles");
      i_rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int b = 0; b < 4; b++) begin
      if (gap > 0) idle($urandom_range(0, gap));
      send_byte(w[8*b +: 8]);
    end
  endtask

  task automatic send_frame(input int n, input int gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum = 32'd0;
`endif
    send_word(32'(n), 0);
    for (int i = 0; i < n; i++) begin
      push_exp(i, wbuf[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum += wbuf[i];
`endif
      send_word(wbuf[i], gap);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(sum, 0);
`endif
  endtask

  task automatic do_start();
    i_start     = 1'b1;
    model_words = 0;
    @(negedge clk);
    i_start = 1'b0;
    check("start_busy", 32'(o_busy), 32'd1);
  endtask

  task automatic check_end(input logic done, input logic err, input int words);
    check("end_done", 32'(o_done), 32'(done));
    check("end_err", 32'(o_err), 32'(err));
    check("end_words", 32'(o_words), 32'(words));
    check("end_ready", 32'(o_rx_ready), 32'd0);
    @(negedge clk);
    check("end_sticky_done", 32'(o_done), 32'(done));
    check("end_pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(o_rx_ready), 32'd0);
    check({tag, "_we"}, 32'(o_mem_we), 32'd0);
    check({tag, "_addr"}, o_mem_addr, 32'd0);
    check({tag, "_data"}, o_mem_data, 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_words"}, 32'(o_words), 32'd0);
  endtask

  // Every strobe must match the oldest outstanding expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (i_rst_n && o_mem_we) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                   o_mem_addr, o_mem_data);
        end else begin
          cur = exp_q.pop_front();
          model_words++;
          check("wr_addr", o_mem_addr, cur.addr);
          check("wr_data", o_mem_data, cur.data);
          check("wr_words", 32'(o_words), 32'(model_words));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    idle(3);
    check_all_zero("rst");
    i_rst_n = 1'b1;
    idle(1);
    check_all_zero("idle");

    // Byte offered in IDLE must not be consumed.
    i_rx_data  = 8'hAA;
    i_rx_valid = 1'b1;
    idle(3);
    i_rx_valid = 1'b0;

    // N=2 hand-computed frame.
    do_start();
    push_exp(0, 32'h0000_0013);
    push_exp(1, 32'h0050_0093);
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    check("t1_we0", 32'(o_mem_we), 32'd1);
    check("t1_addr0", o_mem_addr, 32'h0);
    check("t1_data0", o_mem_data, 32'h0000_0013);
    send_word(32'h0050_0093, 0);
    check("t1_we1", 32'(o_mem_we), 32'd1);
    check("t1_addr1", o_mem_addr, 32'h4);
    check("t1_data1", o_mem_data, 32'h0050_0093);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h0050_00A6, 0);
`endif
    check_end(1'b1, 1'b0, 2);

    // N=0 header.
    do_start();
    send_word(32'd0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t2_busy_chk", 32'(o_busy), 32'd1);
    send_word(32'd0, 0);
`endif
    check_end(1'b1, 1'b0, 0);

    // N=2049 rejected, then recovery with a valid N=1 frame.
    do_start();
    send_word(32'd2049, 0);
    check_end(1'b0, 1'b1, 0);
    i_rx_data  = 8'h55;
    i_rx_valid = 1'b1;
    idle(2);
    i_rx_valid = 1'b0;
    check("t3_err_hold", 32'(o_err), 32'd1);
    do_start();
    check("t3_err_clear", 32'(o_err), 32'd0);
    wbuf[0] = 32'hDEAD_BEEF;
    send_frame(1, 0);
    check_end(1'b1, 1'b0, 1);

    // N=16 with random valid gaps, a back-to-back burst, and an ignored start.
    do_start();
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    send_word(32'd16, 0);
    for (int i = 0; i < 16; i++) begin
      push_exp(i, wbuf[i]);
      send_word(wbuf[i], (i >= 8 && i < 12) ? 0 : 2);
      if (i == 5) begin
        i_start = 1'b1;
        idle(1);
        i_start = 1'b0;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      logic [31:0] s = 32'd0;
      for (int i = 0; i < 16; i++) s += wbuf[i];
      send_word(s, 0);
    end
`endif
    check_end(1'b1, 1'b0, 16);

    // Reset after two bytes of word 3: partial word discarded.
    do_start();
    send_word(32'd4, 0);
    for (int i = 0; i < 3; i++) begin
      wbuf[i] = 32'h1111_1111 * (i + 1);
      push_exp(i, wbuf[i]);
      send_word(wbuf[i], 0);
    end
    send_byte(8'h44);
    send_byte(8'h45);
    #2 i_rst_n = 1'b0;
    #1 check_all_zero("midrst");
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    idle(1);
    check_all_zero("postrst");
    do_start();
    wbuf[0] = 32'hCAFE_F00D;
    send_frame(1, 0);
    check_end(1'b1, 1'b0, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Trailer is the modulo-2^32 sum: 1 + 0xFFFFFFFF = 0.
    do_start();
    push_exp(0, 32'h0000_0001);
    push_exp(1, 32'hFFFF_FFFF);
    send_word(32'd2, 0);
    send_word(32'h0000_0001, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_0000, 0);
    check_end(1'b1, 1'b0, 2);

    do_start();
    push_exp(0, 32'h0000_0001);
    push_exp(1, 32'hFFFF_FFFF);
    send_word(32'd2, 0);
    send_word(32'h0000_0001, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_0001, 0);
    check_end(1'b0, 1'b1, 2);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader and write-side initiator for the 8 KiB instruction memory (2048 x 32-bit, word-addressed by byte address bits [12:2]).
- Accepts a framed byte stream from a UART or host bridge and assembles little-endian words.
- Issues single-cycle word writes to the instruction memory write port.
- Reports busy/done/error so the top level can hold the core in reset until the image is resident.

Parameters:
- DEPTH, 2048, instruction memory capacity in 32-bit words.
- CNT_W, 12, width of the word-count register; must satisfy 2**CNT_W > DEPTH.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle pulse; arms a load (honoured only in IDLE, DONE, ERR).
- i_rx_data  input  8  stream byte.
- i_rx_valid  input  1  byte valid.
- o_rx_ready  output  1  loader accepts byte; a transfer occurs when valid && ready.
- o_mem_we  output  1  one-cycle write strobe to instruction memory.
- o_mem_addr  output  32  byte address of the write; word aligned, bits [1:0] = 0.
- o_mem_data  output  32  write data word.
- o_busy  output  1  high in HDR, DATA, CHK.
- o_done  output  1  level, high in DONE.
- o_err  output  1  level, high in ERR.
- o_words  output  CNT_W  count of words written in the current or last load.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; lane counter, header, and partial word cleared.
- Frame format:
  - 4-byte little-endian header N, the word count.
  - Then N words, each as 4 bytes, LSB first.
- States:
  - IDLE: on i_start go to HDR.
  - HDR: accept 4 bytes into N. After the 4th byte:
    - N > DEPTH -> ERR.
    - N == 0 -> DONE (CHK if CHECKSUM_EN).
    - otherwise -> DATA.
  - DATA: a 2-bit lane counter places the byte at bits [8*lane+7 : 8*lane]. On the lane-3 byte:
    - the next cycle o_mem_we=1 for exactly one cycle, with o_mem_data = assembled word and o_mem_addr = 4*o_words (pre-increment);
    - o_words increments in that same cycle.
    - After word N is issued -> DONE (CHK if CHECKSUM_EN).
  - DONE / ERR: sticky until i_start, which clears o_words and goes to HDR. Otherwise hold.
- Handshake and throughput:
  - o_rx_ready = 1 in HDR, DATA, CHK; 0 elsewhere. It is not a function of i_rx_valid.
  - One byte per cycle is sustainable. The write is registered, so there is no stall.
- Latency: last byte of word k accepted at cycle t -> o_mem_we at t+1; o_done rises at t+1 after the final word.
- Bytes presented while ready=0 are not consumed. There is no implicit drop counter.
- i_start while busy is ignored.
- Reset mid-load: partial word discarded and no write strobe issued. The memory contents are unspecified and the bench must reload.
- Addresses wrap is impossible: N ≤ DEPTH bounds the maximum address at 4*(DEPTH-1).

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - after the last data word, state CHK accepts a 4-byte little-endian trailer;
  - a running 32-bit modulo-2^32 sum of all written words is compared against it;
  - match -> DONE; mismatch -> ERR;
  - for N == 0, the expected trailer is 0.
- Undefined: no CHK state, no trailer consumed, no sum register.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE, HDR, DATA, CHK, DONE, ERR);
  - the IMEM_DEPTH=2048 and IMEM_BYTE_AW=13 constants, shared with the instruction memory.
- One natural sub-module, byte_packer: lane counter plus 32-bit little-endian assembler with a word_valid pulse. It is reused by HDR, DATA, and CHK.

Test Plan:
- Load N=2, bytes 13 00 00 00 then 93 00 50 00 -> o_mem_we at addr 0x0 data 0x00000013, then addr 0x4 data 0x00500093; o_done=1; o_words=2.
- N=0 header -> DONE one cycle after the 4th header byte; no o_mem_we.
- N=2049 header -> o_err=1, o_rx_ready=0, no writes; then i_start plus a valid N=1 frame -> o_err clears and DONE.
- i_rx_valid toggled randomly over N=16 with a back-to-back burst -> 16 strobes at addresses 0x00..0x3C, data matches the stream, no byte lost or duplicated.
- i_rst_n asserted after 2 bytes of word 3 -> all outputs 0 immediately; a new load writes word 0 at addr 0.
- With IMEM_LOADER_CHECKSUM_EN: words 0x1, 0xFFFFFFFF with trailer 0x00000000 -> DONE; with trailer 0x00000001 -> ERR.
